// File: rtl/btn_debounce_ctrl_if.sv
// Button inputs and debounced control outputs of btn_debounce_ctrl.
// The slave modport is the debouncer; the master modport drives the buttons and reads the outputs.
interface btn_debounce_ctrl_if;
   logic i_btn_en;
   logic i_btn_dir;
   logic o_enable;
   logic o_up_down_n;
   logic o_en_pulse;
   logic o_dir_pulse;

   modport master (
      output i_btn_en, i_btn_dir,
      input  o_enable, o_up_down_n, o_en_pulse, o_dir_pulse
   );

   modport slave (
      input  i_btn_en, i_btn_dir,
      output o_enable, o_up_down_n, o_en_pulse, o_dir_pulse
   );
endinterface

// File: rtl/btn_debounce_ctrl.sv
// Two-button debouncer: each button is synchronized, filtered by a press/release FSM,
// and drives a one-cycle press strobe plus a level that toggles on every accepted press.
module btn_debounce_ch #(
   parameter int   DEBOUNCE_CYCLES = 1000000,
   parameter int   CNT_W           = 20,
   parameter logic LVL_RST         = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_pulse,
   output logic o_lvl
);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sync_q, sync_d;
   logic               pulse_q, pulse_d;
   logic               lvl_q, lvl_d;
   logic               sync;

   assign sync = sync_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      sync_d  = {sync_q[0], i_raw};
      case (state_q)
         RELEASED: begin
            if (sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync)                state_d = RELEASED;
            else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               pulse_d = 1'b1;
            end else                  cnt_d = cnt_q + 1'b1;
         end
         PRESSED: begin
            if (!sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A re-press while waiting out the release is a bounce, not a new press.
            if (sync)                 state_d = PRESSED;
            else if (cnt_q == CNT_MAX) state_d = RELEASED;
            else                      cnt_d = cnt_q + 1'b1;
         end
         default: state_d = RELEASED;
      endcase
      lvl_d = lvl_q ^ pulse_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         sync_q  <= '0;
         pulse_q <= 1'b0;
         lvl_q   <= LVL_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync_d;
         pulse_q <= pulse_d;
         lvl_q   <= lvl_d;
      end
   end

   assign o_pulse = pulse_q;
   assign o_lvl   = lvl_q;
endmodule

module btn_debounce_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input logic               i_clk,
   input logic               i_rst,
   btn_debounce_ctrl_if.slave bus
);
   localparam int NUM_BTN = 2;
   // Lane 0 is enable (idles off), lane 1 is direction (idles up).
   localparam logic [NUM_BTN-1:0] LVL_RST = 2'b10;

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] pulse;
   logic [NUM_BTN-1:0] lvl;

   assign raw = {bus.i_btn_dir, bus.i_btn_en};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .LVL_RST         (LVL_RST[g])
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_raw   (raw[g]),
         .o_pulse (pulse[g]),
         .o_lvl   (lvl[g])
      );
   end

   assign bus.o_enable    = lvl[0];
   assign bus.o_up_down_n = lvl[1];
   assign bus.o_en_pulse  = pulse[0];
   assign bus.o_dir_pulse = pulse[1];
endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with DEBOUNCE_CYCLES=4; expected edges and levels are hand-derived.
module tb_btn_debounce_ctrl;
   localparam int DC = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst;

   btn_debounce_ctrl_if bus();

   btn_debounce_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   // Pulse bookkeeping for a window; k counts edges from the first edge after inputs change.
   int   en_n, dir_n, en_k, dir_k;
   logic en_lvl_at, dir_lvl_at;

   task automatic watch(input int n);
      en_n = 0; dir_n = 0; en_k = -1; dir_k = -1;
      en_lvl_at = 1'bx; dir_lvl_at = 1'bx;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (bus.o_en_pulse) begin
            if (en_n == 0) begin en_k = k; en_lvl_at = bus.o_enable; end
            en_n++;
         end
         if (bus.o_dir_pulse) begin
            if (dir_n == 0) begin dir_k = k; dir_lvl_at = bus.o_up_down_n; end
            dir_n++;
         end
      end
   endtask

   int pat [7] = '{1, 1, 0, 1, 1, 0, 0};
   int tot_en;

   initial begin
      rst = 1'b1;
      bus.i_btn_en  = 1'b0;
      bus.i_btn_dir = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_enable",   bus.o_enable,    1'b0);
      chk("rst_updown",   bus.o_up_down_n, 1'b1);
      chk("rst_en_pulse", bus.o_en_pulse,  1'b0);
      chk("rst_dir_pulse",bus.o_dir_pulse, 1'b0);
      rst = 1'b0;

      // Bounce shorter than the debounce window.
      tot_en = 0;
      for (int i = 0; i < 7; i++) begin
         bus.i_btn_en = pat[i][0];
         watch(1);
         tot_en += en_n;
      end
      watch(10);
      tot_en += en_n;
      chk("bounce_pulses", tot_en, 0);
      chk("bounce_enable", bus.o_enable, 1'b0);

      // Clean press.
      bus.i_btn_en = 1'b1;
      watch(20);
      chk("press_count",   en_n, 1);
      chk("press_edge",    en_k, 6);
      chk("press_lvl_at",  en_lvl_at, 1'b1);
      chk("press_enable",  bus.o_enable, 1'b1);
      chk("press_updown",  bus.o_up_down_n, 1'b1);
      chk("press_dir_n",   dir_n, 0);

      // Release bounce: 2 low cycles, then pressed again.
      bus.i_btn_en = 1'b0;
      watch(2);
      tot_en = en_n;
      bus.i_btn_en = 1'b1;
      watch(12);
      tot_en += en_n;
      chk("relbounce_pulses", tot_en, 0);
      chk("relbounce_enable", bus.o_enable, 1'b1);
      bus.i_btn_en = 1'b0;
      watch(12);
      chk("release_pulses", en_n, 0);

      // Simultaneous press from reset.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_btn_en  = 1'b1;
      bus.i_btn_dir = 1'b1;
      watch(12);
      chk("sim_en_n",   en_n, 1);
      chk("sim_dir_n",  dir_n, 1);
      chk("sim_en_k",   en_k, 6);
      chk("sim_dir_k",  dir_k, 6);
      chk("sim_en_lvl", en_lvl_at, 1'b1);
      chk("sim_dir_lvl",dir_lvl_at, 1'b0);
      bus.i_btn_en  = 1'b0;
      bus.i_btn_dir = 1'b0;
      watch(12);

      // Reset during PRESS_WAIT with the button held.
      bus.i_btn_en = 1'b1;
      watch(5);
      chk("midrst_pre_n", en_n, 0);
      rst = 1'b1;
      #1;
      chk("midrst_enable", bus.o_enable,    1'b0);
      chk("midrst_updown", bus.o_up_down_n, 1'b1);
      chk("midrst_pulse",  bus.o_en_pulse,  1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      watch(10);
      chk("midrst_n",      en_n, 1);
      chk("midrst_k",      en_k, 6);
      chk("midrst_en_end", bus.o_enable, 1'b1);
      chk("midrst_ud_end", bus.o_up_down_n, 1'b1);
      bus.i_btn_en = 1'b0;
      watch(12);

      // Two separated direction presses.
      bus.i_btn_dir = 1'b1;
      watch(10);
      chk("dir1_n",  dir_n, 1);
      chk("dir1_k",  dir_k, 6);
      chk("dir1_ud", bus.o_up_down_n, 1'b0);
      bus.i_btn_dir = 1'b0;
      watch(10);
      chk("dirgap_n", dir_n, 0);
      bus.i_btn_dir = 1'b1;
      watch(10);
      chk("dir2_n",  dir_n, 1);
      chk("dir2_k",  dir_k, 6);
      chk("dir2_ud", bus.o_up_down_n, 1'b1);
      chk("dir2_en", bus.o_enable, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
